// File: rtl/accumulator_sequencer_pkg.sv
// Shared types and constants for the accumulator sequencer and its helpers.
package accumulator_sequencer_pkg;

    // Default data width of the accumulator and of the external ripple adder.
    localparam int DEFAULT_WIDTH = 4;

    // Width of the settle counter and of the completed-operation counter.
    localparam int COUNT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_LOAD  = 2'd3
    } op_t;

    // ADD and SUB go through the external adder; CLEAR and LOAD complete immediately.
    function automatic logic is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/accumulator_sequencer_if.sv
// Request handshake between a requester (master) and the accumulator sequencer (slave).
interface accumulator_sequencer_if
    import accumulator_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [WIDTH-1:0] in_b;

    modport master (
        output in_valid,
        output in_op,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_b,
        output in_ready
    );
endinterface

// File: rtl/accumulator_sequencer_settle_timer.sv
// Loadable down-counter that measures the ripple settle time of the external adder.
module settle_timer
    import accumulator_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    output logic                   done
);
    logic [COUNT_WIDTH-1:0] count;
    logic                   armed;

    // Arm and load on request, count down while armed, and disarm once zero has been reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_value;
            armed <= 1'b1;
        end else if (armed) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end else begin
                armed <= 1'b0;
            end
        end
    end

    assign done = armed && (count == '0);
endmodule

// File: rtl/accumulator_sequencer.sv
// Sequential front/back end for an external ripple adder: drives operands, waits for
// the carry chain to settle, then captures the sum into the accumulator.
module accumulator_sequencer
    import accumulator_sequencer_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    accumulator_sequencer_if.slave req,
    input  logic [WIDTH-1:0]       sum_s,
    input  logic                   sum_cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    output logic [WIDTH-1:0]       acc,
    output logic                   acc_valid,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] op_count
);
    state_t state;
    state_t state_next;
    logic   accept;
    logic   start_arith;
    logic   timer_done;
    logic   capture;
    logic   op_is_sub;

    assign accept      = req.in_valid && req.in_ready;
    assign start_arith = accept && is_arith(req.in_op);
    assign capture     = (state == SETTLE) && timer_done;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (start_arith),
        .load_value (COUNT_WIDTH'(SETTLE_CYCLES - 1)),
        .done       (timer_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only ADD/SUB leave IDLE; SETTLE ends on the capture edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_arith) state_next = SETTLE;
            SETTLE:  if (timer_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requests are only taken while idle; the requester holds in_valid otherwise.
    always_comb begin
        req.in_ready = (state == IDLE);
    end

    // Datapath: operand launch at acceptance, immediate CLEAR/LOAD, and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            op_count  <= '0;
            op_is_sub <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (accept) begin
                case (req.in_op)
                    OP_ADD: begin
                        add_a     <= acc;
                        add_b     <= req.in_b;
                        add_cin   <= 1'b0;
                        op_is_sub <= 1'b0;
                    end
                    OP_SUB: begin
                        add_a     <= acc;
                        add_b     <= ~req.in_b;
                        add_cin   <= 1'b1;
                        op_is_sub <= 1'b1;
                    end
                    OP_CLEAR: begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        op_count  <= '0;
                        acc_valid <= 1'b1;
                    end
                    OP_LOAD: begin
                        acc       <= req.in_b;
                        acc_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (capture) begin
                acc       <= sum_s;
                overflow  <= overflow | (op_is_sub ? ~sum_cout : sum_cout);
                op_count  <= op_count + 1'b1;
                acc_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer with a behavioural ripple adder and
// a scoreboard of expected accumulator updates.
module tb_accumulator_sequencer;
    import accumulator_sequencer_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] acc;
        logic         ovf;
        logic [3:0]   cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sum_s;
    logic         sum_cout;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] acc;
    logic         acc_valid;
    logic         overflow;
    logic [3:0]   op_count;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] m_acc = '0;
    logic         m_ovf = 1'b0;
    logic [3:0]   m_cnt = '0;

    accumulator_sequencer_if #(.WIDTH(W)) rq ();

    accumulator_sequencer #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (rq.slave),
        .sum_s     (sum_s),
        .sum_cout  (sum_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .acc       (acc),
        .acc_valid (acc_valid),
        .overflow  (overflow),
        .op_count  (op_count)
    );

    // External ripple adder stand-in.
    assign {sum_cout, sum_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    // Every acc_valid pulse must match the next expected update.
    always @(negedge clk) begin
        if (rst === 1'b0 && acc_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_acc_valid: acc=%0d with no pending update", acc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (acc !== e.acc || overflow !== e.ovf || op_count !== e.cnt) begin
                    failures++;
                    $display("[TB] FAIL scoreboard: got acc=%0d ovf=%0b cnt=%0d, expected acc=%0d ovf=%0b cnt=%0d",
                             acc, overflow, op_count, e.acc, e.ovf, e.cnt);
                end
            end
        end
    end

    task automatic model_reset();
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = '0;
        sb.delete();
    endtask

    task automatic model_accept(input op_t op, input logic [W-1:0] b);
        int t;
        exp_t e;
        case (op)
            OP_CLEAR: begin m_acc = '0; m_ovf = 1'b0; m_cnt = '0; end
            OP_LOAD:  m_acc = b;
            OP_ADD: begin
                t = int'(m_acc) + int'(b);
                if (t > 15) m_ovf = 1'b1;
                m_acc = W'(t % 16);
                m_cnt = m_cnt + 4'd1;
            end
            default: begin
                if (m_acc < b) m_ovf = 1'b1;
                t = int'(m_acc) - int'(b) + 16;
                m_acc = W'(t % 16);
                m_cnt = m_cnt + 4'd1;
            end
        endcase
        e.acc = m_acc;
        e.ovf = m_ovf;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Present a request, hold it until accepted, and return 1 time unit after the accepting edge.
    task automatic send(input op_t op, input logic [W-1:0] b, output int waited);
        rq.in_valid = 1'b1;
        rq.in_op    = op;
        rq.in_b     = b;
        waited      = 0;
        while (rq.in_ready !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (rq.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", rq.in_ready, waited);
            rq.in_valid = 1'b0;
            return;
        end
        model_accept(op, b);
        @(posedge clk); #1;
        rq.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rq.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (rq.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: in_ready=%b, expected 1", rq.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rq.in_valid = 1'b0;
        rq.in_op    = OP_ADD;
        rq.in_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (acc !== 4'd0 || rq.in_ready !== 1'b1 || overflow !== 1'b0 || op_count !== 4'd0 || acc_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: acc=%0d rdy=%b ovf=%b cnt=%0d vld=%b, expected 0 1 0 0 0",
                     acc, rq.in_ready, overflow, op_count, acc_valid);
        end
        checks++;
        if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_operands: a=%0d b=%0d cin=%b, expected 0 0 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (acc !== 4'd0 || rq.in_ready !== 1'b1 || acc_valid !== 1'b0 || op_count !== 4'd0) begin
                failures++;
                $display("[TB] FAIL idle_stable: cycle %0d acc=%0d rdy=%b vld=%b cnt=%0d, expected 0 1 0 0",
                         i, acc, rq.in_ready, acc_valid, op_count);
            end
        end
    endtask

    task automatic test_load_add();
        int w;
        send(OP_LOAD, 4'd3, w);
        send(OP_ADD, 4'd4, w);
        checks++;
        if (add_a !== 4'd3 || add_b !== 4'd4 || add_cin !== 1'b0 || rq.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_launch: a=%0d b=%0d cin=%b rdy=%b, expected 3 4 0 0",
                     add_a, add_b, add_cin, rq.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rq.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_busy2: in_ready=%b, expected 0", rq.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rq.in_ready !== 1'b1 || acc !== 4'd7 || acc_valid !== 1'b1 || op_count !== 4'd1 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_capture: rdy=%b acc=%0d vld=%b cnt=%0d ovf=%b, expected 1 7 1 1 0",
                     rq.in_ready, acc, acc_valid, op_count, overflow);
        end
        @(posedge clk); #1;
        checks++;
        if (acc_valid !== 1'b0 || add_a !== 4'd3 || add_b !== 4'd4) begin
            failures++;
            $display("[TB] FAIL add_after: vld=%b a=%0d b=%0d, expected 0 3 4", acc_valid, add_a, add_b);
        end
    endtask

    task automatic test_wrap();
        int w;
        send(OP_LOAD, 4'd12, w);
        send(OP_ADD, 4'd7, w);
        wait_idle();
        checks++;
        if (acc !== 4'd3 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_wrap: acc=%0d ovf=%b, expected 3 1", acc, overflow);
        end
        send(OP_CLEAR, 4'd0, w);
        checks++;
        if (acc !== 4'd0 || overflow !== 1'b0 || op_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clear: acc=%0d ovf=%b cnt=%0d, expected 0 0 0", acc, overflow, op_count);
        end
    endtask

    task automatic test_sub();
        int w;
        send(OP_LOAD, 4'd2, w);
        send(OP_SUB, 4'd5, w);
        checks++;
        if (add_a !== 4'd2 || add_b !== 4'd10 || add_cin !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sub_launch: a=%0d b=%0d cin=%b, expected 2 10 1", add_a, add_b, add_cin);
        end
        wait_idle();
        checks++;
        if (acc !== 4'd13 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sub_borrow: acc=%0d ovf=%b, expected 13 1", acc, overflow);
        end
        send(OP_CLEAR, 4'd0, w);
        send(OP_LOAD, 4'd9, w);
        send(OP_SUB, 4'd4, w);
        wait_idle();
        checks++;
        if (acc !== 4'd5 || overflow !== 1'b0 || op_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL sub_noborrow: acc=%0d ovf=%b cnt=%0d, expected 5 0 1", acc, overflow, op_count);
        end
    endtask

    task automatic test_busy();
        int w;
        send(OP_LOAD, 4'd4, w);
        send(OP_ADD, 4'd1, w);
        send(OP_SUB, 4'd2, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("[TB] FAIL busy_hold: accepted after %0d waits, expected 2", w);
        end
        wait_idle();
        checks++;
        if (acc !== 4'd3) begin
            failures++;
            $display("[TB] FAIL busy_result: acc=%0d, expected 3", acc);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        send(OP_LOAD, 4'd9, w);
        send(OP_ADD, 4'd5, w);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (acc !== 4'd0 || rq.in_ready !== 1'b1 || overflow !== 1'b0 || op_count !== 4'd0 || acc_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: acc=%0d rdy=%b ovf=%b cnt=%0d vld=%b, expected 0 1 0 0 0",
                     acc, rq.in_ready, overflow, op_count, acc_valid);
        end
        checks++;
        if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_operands: a=%0d b=%0d cin=%b, expected 0 0 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (acc !== 4'd0 || op_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL midreset_nocapture: acc=%0d cnt=%0d, expected 0 0", acc, op_count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        send(OP_CLEAR, 4'd0, w);
        send(OP_LOAD, 4'd6, w);
        for (int i = 0; i < 16; i++) begin
            send(OP_ADD, 4'd0, w);
            if (i > 0) begin
                checks++;
                if (w != 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_wait: op %0d waited %0d, expected 2", i, w);
                end
            end
        end
        wait_idle();
        checks++;
        if (op_count !== 4'd0 || acc !== 4'd6 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL count_wrap: cnt=%0d acc=%0d ovf=%b, expected 0 6 0", op_count, acc, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_wrap();
        test_sub();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d updates pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
- Sequential front/back end for the 4-bit ripple adder.
- Drives the adder operands: A is the stored accumulator, and B and Cin come from the request.
- Waits a programmable settle time for the carry chain to ripple.
- Captures Sum/Cout back into the accumulator, and tracks sticky overflow/borrow and an operation count.

Parameters:
- WIDTH, 4, data width of the accumulator and adder operands.
- SETTLE_CYCLES, 2, cycles allowed for ripple propagation before capture; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe.
- in_ready  output  1  block can accept a request.
- in_op  input  2  operation: 0 = ADD, 1 = SUB, 2 = CLEAR, 3 = LOAD.
- in_b  input  WIDTH  operand for ADD/SUB; value for LOAD.
- sum_s  input  WIDTH  adder Sum bits S0..S3.
- sum_cout  input  1  adder carry out.
- add_a  output  WIDTH  adder operand A; always equals acc while busy.
- add_b  output  WIDTH  adder operand B.
- add_cin  output  1  adder carry in.
- acc  output  WIDTH  accumulator value.
- acc_valid  output  1  one-cycle pulse when acc has just been updated.
- overflow  output  1  sticky flag: ADD carry-out or SUB borrow.
- op_count  output  4  count of completed ADD/SUB operations.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, acc=0, add_a=0, add_b=0, add_cin=0, in_ready=1, acc_valid=0, overflow=0, op_count=0, settle counter=0.
- Reset mid-operation aborts the operation; no capture occurs.
- States: IDLE and SETTLE.
- in_ready=1 only in IDLE. in_valid is ignored when in_ready=0, and the requester holds it.
- A request is accepted at edge E0 when in_valid=1, in_ready=1 and rst=0.
- IDLE, CLEAR accepted: at E0, acc=0, overflow=0, op_count=0, acc_valid=1 for one cycle; state stays IDLE.
- IDLE, LOAD accepted: at E0, acc=in_b, acc_valid=1 for one cycle; overflow and op_count unchanged; state stays IDLE.
- IDLE, ADD accepted: at E0, add_a=acc, add_b=in_b, add_cin=0, counter=SETTLE_CYCLES-1, state=SETTLE, in_ready=0.
- IDLE, SUB accepted: at E0, add_a=acc, add_b=~in_b, add_cin=1, counter=SETTLE_CYCLES-1, state=SETTLE, in_ready=0.
- SETTLE, counter not 0: decrement the counter.
- SETTLE, counter = 0 (capture edge E0+SETTLE_CYCLES):
  - acc = sum_s.
  - ADD: overflow |= sum_cout. SUB: overflow |= ~sum_cout.
  - op_count = op_count+1, wrapping 15 -> 0.
  - acc_valid = 1 for the next cycle.
  - state = IDLE, in_ready = 1.
- Latency: ADD/SUB results appear on acc at edge E0+SETTLE_CYCLES; CLEAR/LOAD results appear at E0.
- Back-to-back: a new request can be accepted at the edge immediately after capture.
- add_a, add_b and add_cin hold their last values in IDLE. They are not cleared after capture.
- acc_valid is never high for two consecutive cycles unless two requests complete on consecutive edges (LOAD followed by LOAD).
- Arithmetic is modulo 2^WIDTH; the wrapped result is stored and overflow is set.
- in_op is sampled only at acceptance; changes during SETTLE have no effect.

Decomposition:
- Shared package:
  - State encodings IDLE=0, SETTLE=1.
  - Op encodings OP_ADD=0, OP_SUB=1, OP_CLEAR=2, OP_LOAD=3.
  - WIDTH default.
- One natural sub-module: settle_timer.
  - Loadable down-counter with a done output that is high when the count is 0 and it is armed.
  - Instantiated once.
- The adder itself stays external and is connected via add_*/sum_* in the parent.

Test Plan:
- Reset then idle: after rst, acc=0, in_ready=1, overflow=0, op_count=0. With no request, nothing changes for 10 cycles.
- LOAD 3 then ADD 4, SETTLE_CYCLES=2:
  - add_a=3, add_b=4, add_cin=0 after acceptance.
  - in_ready=0 for 2 cycles.
  - acc=7 with a one-cycle acc_valid pulse; op_count=1; overflow=0.
- Wrap: LOAD 12 then ADD 7 -> acc=3, overflow=1. A following CLEAR -> acc=0, overflow=0, op_count=0.
- SUB borrow: LOAD 2 then SUB 5 -> add_b=10, add_cin=1, acc=13, overflow=1. LOAD 9 then SUB 4 -> acc=5, overflow stays 0.
- Busy and reset:
  - An ADD request held during SETTLE is not accepted until in_ready returns.
  - Separately, asserting rst during SETTLE gives reset values on the next cycle, with no acc_valid pulse.
- op_count wrap: 16 consecutive ADD 0 operations -> op_count returns to 0 and acc is unchanged.
